// File: rtl/data_sram_resp_if.sv
`default_nettype none
// ============================================================================
// data_sram_resp_if : request/response bus of the word SRAM responder
// Rev 1.0
// ============================================================================
interface data_sram_resp_if;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        err_clr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        err_sticky;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  modport master (
    output en, we, addr, wdata, err_clr,
    input  rdata, rvalid, err, err_sticky, rd_cnt, wr_cnt
  );

  modport slave (
    input  en, we, addr, wdata, err_clr,
    output rdata, rvalid, err, err_sticky, rd_cnt, wr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// data_sram_resp : word SRAM with fixed-latency read pipeline and error flags
// Rev 1.0
// ============================================================================
module data_sram_resp #(
  parameter logic [31:0] BASE  = 32'h1C00_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  data_sram_resp_if.slave bus
);

  localparam int          c_IDX_W = $clog2(DEPTH);
  localparam logic [31:0] c_SPAN  = 32'(DEPTH) * 32'd4;

  logic [31:0]          mem [DEPTH];

  logic [31:0]          w_offset;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_good;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_bad;
  logic [31:0]          w_rd_word;

  logic [LAT-1:0]       r_vld;
  logic [LAT-1:0][31:0] r_dat;
  logic                 r_err;
  logic                 r_err_sticky;
  logic [15:0]          r_rd_cnt;
  logic [15:0]          r_wr_cnt;

  // Offset wraps modulo 2^32, so addresses below BASE land far out of range.
  assign w_offset  = bus.addr - BASE;
  assign w_idx     = w_offset[c_IDX_W+1:2];
  assign w_good    = (w_offset < c_SPAN) && (bus.addr[1:0] == 2'b00);
  assign w_acc     = bus.en && !reset;
  assign w_wr      = w_acc && bus.we && w_good;
  assign w_rd      = w_acc && !bus.we;
  assign w_bad     = w_acc && !w_good;
  assign w_rd_word = w_good ? mem[w_idx] : 32'h0000_0000;

  // No reset on the array: contents survive reset. Read-first falls out of
  // sampling mem[] combinationally before this edge's update lands.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem[w_idx] <= bus.wdata;
    end
  end

  // Stage k holds a read sampled k edges ago; data only moves with a valid
  // token so the last stage keeps its value between deliveries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_dat[0] <= w_rd_word;
      end
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (w_bad) begin
        r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= 16'h0000;
      r_wr_cnt <= 16'h0000;
    end else begin
      if (w_rd && w_good && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'h0001;
      end
      if (w_wr && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'h0001;
      end
    end
  end

  assign bus.rdata      = r_dat[LAT-1];
  assign bus.rvalid     = r_vld[LAT-1];
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;
  assign bus.rd_cnt     = r_rd_cnt;
  assign bus.wr_cnt     = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// tb_data_sram_resp : randomized scoreboard bench for data_sram_resp
// Rev 1.0
// ============================================================================
module tb_data_sram_resp;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  typedef struct {
    int unsigned at_cyc;
    logic [31:0] data;
  } rd_exp_t;

  logic clk;
  logic reset;
  data_sram_resp_if bus ();

  data_sram_resp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain word array plus expectation queues.
  logic [31:0] mem_m [DEPTH];
  rd_exp_t     rd_q [$];
  int unsigned err_q [$];
  logic [31:0] last_rdata;
  logic        sticky_m;
  logic [15:0] rd_m;
  logic [15:0] wr_m;
  bit          chk_en = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        bit exp_v;
        bit exp_e;
        exp_v = (rd_q.size() > 0) && (rd_q[0].at_cyc == cyc);
        chk("rvalid", {31'b0, bus.rvalid}, {31'b0, exp_v});
        if (exp_v) last_rdata = rd_q[0].data;
        while ((rd_q.size() > 0) && (rd_q[0].at_cyc <= cyc)) void'(rd_q.pop_front());
        chk("rdata", bus.rdata, last_rdata);
        exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
        chk("err", {31'b0, bus.err}, {31'b0, exp_e});
        while ((err_q.size() > 0) && (err_q[0] <= cyc)) void'(err_q.pop_front());
        chk("err_sticky", {31'b0, bus.err_sticky}, {31'b0, sticky_m});
        chk("rd_cnt", {16'h0, bus.rd_cnt}, {16'h0, rd_m});
        chk("wr_cnt", {16'h0, bus.wr_cnt}, {16'h0, wr_m});
      end
    end
  end

  // One request per cycle; the model is updated as the request is issued.
  task automatic drive(input bit e, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit clr);
    logic [31:0] off;
    bit          good;
    int unsigned n;
    @(negedge clk);
    reset       = 1'b0;
    bus.en      = e;
    bus.we      = w;
    bus.addr    = a;
    bus.wdata   = d;
    bus.err_clr = clr;
    n    = cyc + 1;
    off  = a - BASE;
    good = (off < DEPTH * 4) && (a % 4 == 0);
    if (e && !good) begin
      sticky_m = 1'b1;
      err_q.push_back(n);
    end else if (clr) begin
      sticky_m = 1'b0;
    end
    if (e && w && good) begin
      mem_m[off / 4] = d;
      if (wr_m != 16'hFFFF) wr_m++;
    end
    if (e && !w) begin
      rd_q.push_back('{at_cyc: n + LAT - 1, data: good ? mem_m[off / 4] : 32'h0});
      if (good && rd_m != 16'hFFFF) rd_m++;
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset       = 1'b1;
      bus.en      = 1'($urandom);
      bus.we      = 1'($urandom);
      bus.addr    = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      bus.wdata   = $urandom;
      bus.err_clr = 1'($urandom);
      rd_q.delete();
      err_q.delete();
      last_rdata = 32'h0;
      sticky_m   = 1'b0;
      rd_m       = 16'h0;
      wr_m       = 16'h0;
      chk_en     = 1;
    end
  endtask

  function automatic logic [31:0] good_addr();
    return BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  task automatic random_access();
    int unsigned r;
    bit          clr;
    r   = $urandom_range(0, 99);
    clr = ($urandom_range(0, 9) == 0);
    if (r < 10)      drive(0, 1'($urandom), $urandom, $urandom, clr);
    else if (r < 50) drive(1, 1, good_addr(), $urandom, clr);
    else if (r < 85) drive(1, 0, good_addr(), $urandom, clr);
    else if (r < 90) drive(1, 1'($urandom), good_addr() | 32'($urandom_range(1, 3)), $urandom, clr);
    else if (r < 95) drive(1, 1'($urandom), BASE + DEPTH * 4 + ($urandom & 32'h0FFF_FFFC), $urandom, clr);
    else             drive(1, 1'($urandom), BASE - 4 - ($urandom & 32'h000F_FFFC), $urandom, clr);
  endtask

  initial begin
    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 32'h0;
    bus.wdata   = 32'h0;
    bus.err_clr = 1'b0;
    do_reset(3);

    for (int i = 0; i < DEPTH; i++) drive(1, 1, BASE + 32'(i * 4), $urandom, 0);
    do_reset(1);

    // Write then read back, counters both one
    drive(1, 1, 32'h1C00_0010, 32'hCAFE_0001, 0);
    drive(1, 0, 32'h1C00_0010, 32'h0, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk("rd_cnt_after_rw", {16'h0, bus.rd_cnt}, 32'd1);
    chk("wr_cnt_after_rw", {16'h0, bus.wr_cnt}, 32'd1);

    // Old value, overwrite, back-to-back reads
    drive(1, 1, 32'h1C00_0020, 32'h1111_1111, 0);
    drive(1, 0, 32'h1C00_0020, 32'h0, 0);
    drive(1, 1, 32'h1C00_0020, 32'h2222_2222, 0);
    drive(1, 0, 32'h1C00_0020, 32'h0, 0);

    // Misaligned write, out-of-range read, then confirm word 0 untouched
    drive(1, 1, 32'h1C00_0002, 32'hDEAD_BEEF, 0);
    drive(1, 0, 32'h1C00_1000, 32'h0, 0);
    drive(1, 0, 32'h1C00_0000, 32'h0, 0);
    drive(0, 0, 32'h0, 32'h0, 1);

    // Consecutive reads of words 0..3
    for (int i = 0; i < 4; i++) drive(1, 1, BASE + 32'(i * 4), 32'(10 + i), 0);
    for (int i = 0; i < 4; i++) drive(1, 0, BASE + 32'(i * 4), 32'h0, 0);
    drive(0, 0, 32'h0, 32'h0, 0);

    // Read killed by reset one cycle later, then re-read after release
    drive(1, 0, 32'h1C00_0008, 32'h0, 0);
    do_reset(1);
    drive(1, 0, 32'h1C00_0008, 32'h0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset($urandom_range(1, 3));
      random_access();
    end

    // wr_cnt saturation
    do_reset(1);
    for (int i = 0; i < 65537; i++) drive(1, 1, good_addr(), $urandom, 0);
    drive(0, 0, 32'h0, 32'h0, 0);
    chk("wr_cnt_saturated", {16'h0, bus.wr_cnt}, 32'h0000_FFFF);

    for (int i = 0; i < LAT + 2; i++) drive(0, 0, 32'h0, 32'h0, 0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
